// File: rtl/cv_bus_deser.sv
// Per-lane 1:RATIO deserializer: NLANE serial lanes widened to RATIO-bit words,
// lane k's word at out[k*RATIO +: RATIO], valid/ready on both sides.
module cv_bus_deser #(
  parameter int NLANE = 2,
  parameter int RATIO = 2,
  parameter int DCW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NLANE-1:0]       in,
  input  logic                   in_valid,
  input  logic                   in_sync,
  output logic                   in_ready,
  output logic [NLANE*RATIO-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DCW-1:0]         drop_cnt
);
  localparam int W  = NLANE * RATIO;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   acc_reg, acc_next, word_next, out_reg;
  logic           out_valid_reg, out_valid_next;
  logic [DCW-1:0] drop_reg, drop_next;
  logic [CW-1:0]  beat_idx;
  logic           accept, load, drop;

  // Only a final beat can be refused, and only while the output word is stuck.
  assign in_ready = (cnt_reg != LAST) | ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;
  assign beat_idx = in_sync ? '0 : cnt_reg;
  assign load     = accept & ~in_sync & (cnt_reg == LAST);
  assign drop     = in_sync & (cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      logic [RATIO-1:0] lane_next;
      always_comb begin
        lane_next = in_sync ? '0 : acc_reg[gi*RATIO +: RATIO];
        if (accept) lane_next[beat_idx] = in[gi];
      end
      assign word_next[gi*RATIO +: RATIO] = lane_next;
    end
  endgenerate

  assign acc_next       = load ? '0 : word_next;
  assign out_valid_next = load | (out_valid_reg & ~out_ready);
  assign drop_next      = (drop && (drop_reg != '1)) ? drop_reg + 1'b1 : drop_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (in_sync)
      cnt_next = accept ? CW'(1) : '0;
    else if (accept)
      cnt_next = load ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      drop_reg      <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      out_valid_reg <= out_valid_next;
      drop_reg      <= drop_next;
      if (load) out_reg <= word_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign drop_cnt  = drop_reg;
endmodule

// File: tb/tb_cv_bus_deser.sv
// Scoreboard bench for cv_bus_deser: driver feeds a beat-list reference model,
// monitor pops expected words whenever the DUT presents one.
module tb_cv_bus_deser;
  localparam int NLANE = 2;
  localparam int RATIO = 2;
  localparam int DCW   = 8;
  localparam int W     = NLANE * RATIO;
  localparam int DMAX  = (1 << DCW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NLANE-1:0] in = '0;
  logic             in_valid = 1'b0;
  logic             in_sync = 1'b0;
  logic             in_ready;
  logic [W-1:0]     out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DCW-1:0]   drop_cnt;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Reference model: beats of the word being collected, completed words, drops.
  logic [NLANE-1:0] part[$];
  logic [W-1:0]     exp_q[$];
  int               drops = 0;

  cv_bus_deser #(.NLANE(NLANE), .RATIO(RATIO), .DCW(DCW)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic cycle(input bit v, input bit s, input logic [NLANE-1:0] d, input bit ordy);
    bit exp_rdy;
    bit acc;
    logic [W-1:0] w;
    @(negedge clk);
    in_valid = v; in_sync = s; in = d; out_ready = ordy;
    #1;
    exp_rdy = !((part.size() == RATIO - 1) && (exp_q.size() > 0) && !ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("drop_cnt", 32'(drop_cnt), 32'(drops));
    acc = v && exp_rdy;
    @(posedge clk);
    if (s) begin
      if (part.size() != 0 && drops < DMAX) drops++;
      part.delete();
    end
    if (acc) begin
      part.push_back(d);
      if (part.size() == RATIO) begin
        w = '0;
        for (int j = 0; j < RATIO; j++)
          for (int k = 0; k < NLANE; k++)
            w[k*RATIO + j] = part[j][k];
        exp_q.push_back(w);
        $display("word expected %0h", w);
        part.delete();
      end
    end
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out", 32'(out), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst drop_cnt", 32'(drop_cnt), 32'd0);
    part.delete(); exp_q.delete(); drops = 0;
    in_valid = 1'b0; in_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare the presented word against the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (out_valid && exp_q.size() > 0) begin
          check("out word", 32'(out), 32'(exp_q[0]));
          if (out_ready) begin
            $display("word consumed %0h", out);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #7;
    check("init out_valid", 32'(out_valid), 32'd0);
    check("init out", 32'(out), 32'd0);
    check("init in_ready", 32'(in_ready), 32'd1);
    check("init drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Sync-aligned word 10 / 01 -> 0110
    cycle(1, 1, 2'b10, 1);
    cycle(1, 0, 2'b01, 1);
    #1;
    check("t1 out", 32'(out), 32'h6);
    check("t1 out_valid", 32'(out_valid), 32'd1);
    cycle(0, 0, 2'b00, 1);

    // Back-to-back beats
    for (int i = 0; i < 8; i++) cycle(1, i == 0, 2'($urandom), 1);
    cycle(0, 0, 2'b00, 1);

    // Stalled final beat, then released
    cycle(1, 1, 2'b11, 0);
    cycle(1, 0, 2'b10, 0);
    cycle(1, 0, 2'b01, 0);
    cycle(1, 0, 2'b11, 0);
    cycle(1, 0, 2'b11, 1);
    cycle(0, 0, 2'b00, 1);
    cycle(0, 0, 2'b00, 1);

    // Resync over a partial word
    cycle(1, 0, 2'b10, 1);
    cycle(1, 1, 2'b11, 1);
    cycle(1, 0, 2'b00, 1);
    #1;
    check("t4 out", 32'(out), 32'h5);
    check("t4 drop_cnt", 32'(drop_cnt), 32'd1);
    cycle(0, 0, 2'b00, 1);

    // Drop counter saturation
    for (int i = 0; i < DMAX + 3; i++) begin
      cycle(1, 0, 2'($urandom), 1);
      cycle(0, 1, 2'b00, 1);
    end
    #1;
    check("t5 drop_cnt sat", 32'(drop_cnt), 32'd255);

    // Reset with a word pending and a partial word in flight
    cycle(1, 1, 2'b01, 0);
    cycle(1, 0, 2'b10, 0);
    cycle(1, 0, 2'b11, 0);
    mid_reset();
    cycle(1, 0, 2'b10, 1);
    cycle(1, 0, 2'b01, 1);
    #1;
    check("t6 out", 32'(out), 32'h6);

    // Random traffic with an embedded reset
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) mid_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            2'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
